// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage sitting between the PC register and decode.
// Issues the current PC to instruction memory (req/gnt/rvalid, one fetch
// outstanding), steps the PC register on every accepted request, buffers returned
// words with their PCs in a QDEPTH-entry circular queue and hands them to decode
// over valid/ready. A redirect (flush_i) empties the queue and discards any
// fetch that is still in flight.
//
// Optional feature: define IFETCH_MISALIGN_EN to trap PCs with non-zero low bits.
// A trapped PC produces a queue entry flagged with dec_exc_o and parks the unit
// in HOLD until the next redirect. With the macro undefined, the low address bits
// are forced to 00 and dec_exc_o is tied low.
module ifetch_unit #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic        pc_ena_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        flush_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_inst_o,
    output logic [31:0] dec_pc_o,
    output logic        dec_exc_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
`ifdef IFETCH_MISALIGN_EN
        ,
        S_HOLD    = 2'd3
`endif
    } state_e;

    state_e             state_q;
    logic [31:0]        pend_pc_q;

    logic [31:0]        pc_mem_q   [QDEPTH];
    logic [31:0]        inst_mem_q [QDEPTH];
`ifdef IFETCH_MISALIGN_EN
    logic               exc_mem_q  [QDEPTH];
`endif

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               in_idle;
    logic               has_room;
    logic               misalign;
    logic               grant;
    logic               resp_push;
    logic               trap_push;
    logic               push;
    logic               pop;
    logic [31:0]        push_pc;
    logic [31:0]        push_inst;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign in_idle  = (state_q == S_IDLE);
    assign has_room = (count_q < DEPTH_C);

`ifdef IFETCH_MISALIGN_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A request only leaves IDLE when a queue slot is guaranteed for its reply;
    // a redirect in the same cycle suppresses it because pc_i is about to change.
    assign imem_req_o  = !rst && in_idle && has_room && !flush_i && !misalign;
    assign imem_addr_o = {pc_i[31:2], 2'b00};
    assign grant       = imem_req_o && imem_gnt_i;

    // The PC register steps on an accepted fetch and loads the target on a redirect.
    // While a request waits for grant this stays low, holding imem_addr_o stable.
    assign pc_ena_o = !rst && (grant || flush_i);

    // ------------------------------------------------------------------
    // Queue push / pop
    // ------------------------------------------------------------------
    assign resp_push = (state_q == S_WAIT) && imem_rvalid_i && !flush_i;
    assign trap_push = in_idle && has_room && !flush_i && misalign;
    assign push      = resp_push || trap_push;

    assign dec_valid_o = !rst && (count_q != '0) && !flush_i;
    assign pop         = dec_valid_o && dec_ready_i;

    assign push_pc   = trap_push ? pc_i  : pend_pc_q;
    assign push_inst = trap_push ? 32'h0 : imem_rdata_i;

    // Next pointers and occupancy; a redirect empties the queue outright.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue pointers and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage: the entry at the write pointer is filled on every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset because the decode head fields read it directly and must be 0 out of reset.
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
`ifdef IFETCH_MISALIGN_EN
                exc_mem_q[i]  <= 1'b0;
`endif
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= push_pc;
            inst_mem_q[wr_ptr_q] <= push_inst;
`ifdef IFETCH_MISALIGN_EN
            exc_mem_q[wr_ptr_q]  <= trap_push;
`endif
        end
    end

    // Head of queue goes straight from storage to decode.
    assign dec_pc_o   = pc_mem_q[rd_ptr_q];
    assign dec_inst_o = inst_mem_q[rd_ptr_q];
`ifdef IFETCH_MISALIGN_EN
    assign dec_exc_o  = exc_mem_q[rd_ptr_q];
`else
    assign dec_exc_o  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Fetch control FSM
    // ------------------------------------------------------------------
    // Tracks the single outstanding fetch and whether its reply must be dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_pc_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        pend_pc_q <= pc_i;
                        state_q   <= S_WAIT;
                    end
`ifdef IFETCH_MISALIGN_EN
                    else if (trap_push) begin
                        state_q <= S_HOLD;
                    end
`endif
                end
                S_WAIT: begin
                    // A reply arriving together with a redirect is dropped by resp_push.
                    if (imem_rvalid_i) begin
                        state_q <= S_IDLE;
                    end else if (flush_i) begin
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    // The stale reply is swallowed; further redirects change nothing here.
                    if (imem_rvalid_i) begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef IFETCH_MISALIGN_EN
                S_HOLD: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. A behavioural PC register and instruction
// memory surround the DUT; every granted fetch pushes its expected
// {pc, inst, exc} into a scoreboard queue, and every decode handshake pops and
// compares. A redirect empties the scoreboard, since all queued and in-flight
// fetches are discarded. Directed checks cover reset, timing and flush corners.
module tb_ifetch_unit;

    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_ena_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        flush_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_inst_o;
    logic [31:0] dec_pc_o;
    logic        dec_exc_o;

    always #5 clk = ~clk;

    ifetch_unit #(.QDEPTH(QDEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_ena_o      (pc_ena_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .flush_i       (flush_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_inst_o    (dec_inst_o),
        .dec_pc_o      (dec_pc_o),
        .dec_exc_o     (dec_exc_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];

    // Per-cycle stimulus staged by the test sequence, applied at the next negedge.
    logic        flush_s = 1'b0;
    logic        ready_s = 1'b0;
    logic [31:0] tgt_s   = '0;
    logic [31:0] pc_nx   = '0;
    int          gnt_budget = 0;   // -1 grants forever, otherwise grants left
    int          lat        = 1;   // grant-to-rvalid cycles

    // Memory model state.
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_data = '0;

    int          n_grants = 0;
    int          n_pops   = 0;
    int          n_pc_ena = 0;
    logic [31:0] last_pop_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, grant combinationally,
    // then observe outputs and update the models before the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        pc_i          = pc_nx;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_data;
                mem_busy      = 1'b0;
            end
        end
        flush_i     = flush_s;
        dec_ready_i = ready_s;
        imem_gnt_i  = 1'b0;
        #1;
        if (imem_req_o && gnt_budget != 0 && !mem_busy) begin
            imem_gnt_i = 1'b1;
            if (gnt_budget > 0) gnt_budget--;
        end
        #1;
        if (pc_ena_o) n_pc_ena++;
        if (flush_i) sb.delete();
        if (dec_valid_o && dec_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pc",   dec_pc_o,   e.pc);
                check("sb_inst", dec_inst_o, e.inst);
                check("sb_exc",  {31'd0, dec_exc_o}, {31'd0, e.exc});
            end
            last_pop_pc = dec_pc_o;
            n_pops++;
        end
        if (imem_req_o && imem_gnt_i) begin
            check("grant_addr", imem_addr_o, {pc_i[31:2], 2'b00});
            e.pc   = pc_i;
            e.inst = mem_word({pc_i[31:2], 2'b00});
            e.exc  = 1'b0;
            sb.push_back(e);
            mem_busy = 1'b1;
            mem_cnt  = lat;
            mem_data = e.inst;
            n_grants++;
        end
        pc_nx = flush_i ? tgt_s : (pc_ena_o ? pc_i + 32'd4 : pc_i);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        flush_s = 1'b1;
        tgt_s   = tgt;
        tick();
        check("flush_pcena", {31'd0, pc_ena_o},    32'd1);
        check("flush_valid", {31'd0, dec_valid_o}, 32'd0);
        flush_s = 1'b0;
    endtask

    task automatic wait_grant();
        int g;
        bit seen;
        g    = n_grants;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (n_grants != g) seen = 1'b1;
        end
        if (!seen) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic quiesce();
        gnt_budget = 0;
        ready_s    = 1'b1;
        repeat (10) tick();
        check("drained_valid", {31'd0, dec_valid_o}, 32'd0);
        check("drained_sb",    sb.size(),            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int g0;
        bit done;
        rst           = 1'b1;
        pc_i          = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        flush_i       = 1'b0;
        dec_ready_i   = 1'b0;

        // Reset state.
        tick();
        check("rst_req",   {31'd0, imem_req_o},  32'd0);
        check("rst_pcena", {31'd0, pc_ena_o},    32'd0);
        check("rst_valid", {31'd0, dec_valid_o}, 32'd0);
        check("rst_pc",    dec_pc_o,             32'd0);
        check("rst_inst",  dec_inst_o,           32'd0);
        check("rst_exc",   {31'd0, dec_exc_o},   32'd0);
        flush_s = 1'b1;
        tgt_s   = 32'h0040_0000;
        tick();
        check("rst_pcena_flush", {31'd0, pc_ena_o},   32'd0);
        check("rst_req_flush",   {31'd0, imem_req_o}, 32'd0);
        flush_s = 1'b0;
        rst     = 1'b0;

        // Reset sequencing: first fetch, earliest delivery to decode.
        gnt_budget = 1;
        lat        = 1;
        ready_s    = 1'b0;
        n_pc_ena   = 0;
        tick();
        check("seq_req",   {31'd0, imem_req_o}, 32'd1);
        check("seq_addr",  imem_addr_o,         32'h0040_0000);
        check("seq_pcena", {31'd0, pc_ena_o},   32'd1);
        tick();
        check("seq_valid_n1", {31'd0, dec_valid_o}, 32'd0);
        tick();
        check("seq_valid_n2", {31'd0, dec_valid_o}, 32'd1);
        check("seq_pc",       dec_pc_o,             32'h0040_0000);
        check("seq_inst",     dec_inst_o,           32'h2008_0005);
        check("seq_exc",      {31'd0, dec_exc_o},   32'd0);
        tick();
        check("seq_pcena_once", n_pc_ena, 32'd1);
        ready_s = 1'b1;
        tick();
        ready_s = 1'b0;

        // Backpressure: two entries fill the queue and fetching stops.
        redirect(32'h0040_0000);
        gnt_budget = -1;
        lat        = 1;
        ready_s    = 1'b0;
        g0         = n_grants;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i >= 4) check("bp_noreq", {31'd0, imem_req_o}, 32'd0);
        end
        check("bp_grants", n_grants - g0,        32'd2);
        check("bp_valid",  {31'd0, dec_valid_o}, 32'd1);
        ready_s = 1'b1;
        tick();
        check("bp_pop_head",  dec_pc_o,            32'h0040_0000);
        check("bp_pop_noreq", {31'd0, imem_req_o}, 32'd0);
        ready_s = 1'b0;
        tick();
        check("bp_resume_req",  {31'd0, imem_req_o}, 32'd1);
        check("bp_resume_addr", imem_addr_o,         32'h0040_0008);
        quiesce();

        // Flush in WAIT: reply three cycles after the flush is dropped.
        lat        = 4;
        ready_s    = 1'b1;
        gnt_budget = 1;
        wait_grant();
        flush_s = 1'b1;
        tgt_s   = 32'h0050_0000;
        tick();
        check("wflush_pcena", {31'd0, pc_ena_o},    32'd1);
        check("wflush_valid", {31'd0, dec_valid_o}, 32'd0);
        check("wflush_req",   {31'd0, imem_req_o},  32'd0);
        flush_s    = 1'b0;
        gnt_budget = 1;
        tick();
        check("discard_req_a", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("discard_req_b", {31'd0, imem_req_o}, 32'd0);
        tick();
        check("discard_req_rv",   {31'd0, imem_req_o},  32'd0);
        check("discard_valid_rv", {31'd0, dec_valid_o}, 32'd0);
        tick();
        check("wflush_empty",    {31'd0, dec_valid_o}, 32'd0);
        check("wflush_next_req", {31'd0, imem_req_o},  32'd1);
        check("wflush_next_pc",  imem_addr_o,          32'h0050_0000);
        quiesce();

        // Flush coinciding with rvalid and dec_ready_i.
        lat        = 2;
        ready_s    = 1'b0;
        gnt_budget = 2;
        wait_grant();
        tick();
        tick();
        wait_grant();
        tick();
        check("fr_pre_valid", {31'd0, dec_valid_o}, 32'd1);
        flush_s = 1'b1;
        ready_s = 1'b1;
        tgt_s   = 32'h0060_0000;
        tick();
        check("fr_valid", {31'd0, dec_valid_o}, 32'd0);
        check("fr_pcena", {31'd0, pc_ena_o},    32'd1);
        flush_s    = 1'b0;
        gnt_budget = 1;
        tick();
        check("fr_valid_next", {31'd0, dec_valid_o}, 32'd0);
        check("fr_req",        {31'd0, imem_req_o},  32'd1);
        check("fr_addr",       imem_addr_o,          32'h0060_0000);
        quiesce();

        // Wrap-around: ten fetches with decode readiness toggling.
        redirect(32'h0040_0000);
        gnt_budget = 10;
        lat        = 1;
        p0         = n_pops;
        g0         = n_grants;
        done       = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            ready_s = (i % 2 == 0);
            tick();
            if (n_pops - p0 == 10) done = 1'b1;
        end
        check("wrap_pops",   n_pops - p0,   32'd10);
        check("wrap_grants", n_grants - g0, 32'd10);
        check("wrap_last",   last_pop_pc,   32'h0040_0024);
        ready_s = 1'b1;
        repeat (4) tick();
        check("wrap_nodup_valid", {31'd0, dec_valid_o}, 32'd0);
        check("wrap_nodup_pops",  n_pops - p0,          32'd10);
        quiesce();

`ifdef IFETCH_MISALIGN_EN
        // Misaligned PC: exception entry, no memory traffic until a redirect.
        ready_s    = 1'b0;
        gnt_budget = -1;
        redirect(32'h0040_0002);
        g0 = n_grants;
        tick();
        check("mis_req",   {31'd0, imem_req_o}, 32'd0);
        check("mis_pcena", {31'd0, pc_ena_o},   32'd0);
        tick();
        check("mis_valid", {31'd0, dec_valid_o}, 32'd1);
        check("mis_exc",   {31'd0, dec_exc_o},   32'd1);
        check("mis_pc",    dec_pc_o,             32'h0040_0002);
        check("mis_inst",  dec_inst_o,           32'h0);
        repeat (3) tick();
        check("mis_hold_req",    {31'd0, imem_req_o}, 32'd0);
        check("mis_hold_grants", n_grants - g0,       32'd0);
        redirect(32'h0040_0008);
        tick();
        check("mis_resume_req",  {31'd0, imem_req_o}, 32'd1);
        check("mis_resume_addr", imem_addr_o,         32'h0040_0008);
        quiesce();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage between the PC register and decode. Issues the current PC to instruction memory over a request/grant/rvalid handshake and advances the PC register on each accepted request. Buffers returned instructions with their PCs in a small queue, and presents them to decode over a valid/ready handshake. On branch/jump redirect it discards all queued and in-flight fetches.

## Interface
- QDEPTH, 2, instruction queue entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_i  in  32  current PC from PC register output
- pc_ena_o  out  1  load enable to PC register
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch byte address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid
- imem_rdata_i  in  32  instruction word
- flush_i  in  1  redirect; external next-PC mux presents target to PC register this cycle
- dec_valid_o  out  1  queue head valid
- dec_ready_i  in  1  decode accepts head
- dec_inst_o  out  32  head instruction
- dec_pc_o  out  32  head PC
- dec_exc_o  out  1  head carries misaligned-fetch exception

## Operation
- Single outstanding fetch. States: IDLE, WAIT, DISCARD, plus HOLD when IFETCH_MISALIGN_EN is defined.
- Reset: state IDLE, queue empty, count 0. All registered outputs are 0. With rst high, imem_req_o=0, pc_ena_o=0, dec_valid_o=0.
- IDLE:
  - imem_req_o = (count < QDEPTH) & !flush_i.
  - imem_addr_o = {pc_i[31:2],2'b00}.
  - On req & gnt: capture pc_i into pend_pc and go to WAIT.
- WAIT: on rvalid, push {pend_pc, imem_rdata_i, exc=0} and go to IDLE. A slot is always free because issue required count < QDEPTH.
- pc_ena_o = (imem_req_o & imem_gnt_i) | flush_i. This is a combinational pulse; on a flush it loads the redirect target.
- Queue is a circular buffer with read and write pointers that wrap modulo QDEPTH.
  - dec_valid_o = (count != 0) & !flush_i. Head fields come straight from the registered storage.
  - Pop on dec_valid_o & dec_ready_i. Push and pop in the same cycle leave count unchanged.
- flush_i, which has priority over push and pop:
  - The queue is cleared on the next edge.
  - In IDLE: no request issues that cycle.
  - In WAIT without rvalid: go to DISCARD.
  - In WAIT with rvalid: the data is dropped and the state goes to IDLE.
  - In DISCARD: stay in DISCARD.
- DISCARD: no requests. On rvalid, drop the data and go to IDLE.
- Reset mid-transaction returns to IDLE immediately. Memory is required to abandon the in-flight response on rst.

## Timing
- Earliest sequence: req+gnt in cycle N, rvalid in N+1, dec_valid_o in N+2.
- Peak throughput is 1 instruction per 2 cycles.
- imem_addr_o stays stable while a request waits for grant, because pc_ena_o is low.
- A flush in cycle N gives dec_valid_o=0 in N and N+1. The first request to the new PC can be issued in N+1, or later if the state was WAIT or DISCARD.

## Configuration
- IFETCH_MISALIGN_EN defined:
  - In IDLE, if pc_i[1:0] != 0 and count < QDEPTH, no memory request is made.
  - The block pushes {pc_i, 32'h0, exc=1}, leaves pc_ena_o low, and enters HOLD.
  - HOLD issues nothing until flush_i, then goes to IDLE.
- IFETCH_MISALIGN_EN undefined: dec_exc_o is tied to 0, and the low address bits are forced to 00 with no check.

## Test plan
- Reset sequencing:
  - Stimulus: rst pulse, then pc_i=32'h0040_0000; memory grants immediately and returns 32'h2008_0005 in the next cycle.
  - Required response: pc_ena_o pulses once.
  - Required response: two cycles after the grant, dec_valid_o=1 with dec_pc_o=32'h0040_0000 and dec_inst_o=32'h2008_0005.
- Backpressure:
  - Stimulus: dec_ready_i=0 while fetching pc_i=0x00400000, then 0x00400004.
  - Required response: after 2 entries, imem_req_o stays 0.
  - Required response: setting dec_ready_i=1 pops 0x00400000 first, then the next request issues.
- Flush in WAIT:
  - Stimulus: flush_i in the cycle after a grant, with rvalid arriving 3 cycles later.
  - Required response: the response is dropped, the queue is empty, and pc_ena_o=1 in the flush cycle.
  - Required response: the next request uses the new pc_i.
- Flush coinciding with rvalid and dec_ready_i:
  - Required response: no push, no pop, and dec_valid_o=0 in the next cycle.
- Wrap-around:
  - Stimulus: 10 sequential fetches with dec_ready_i toggled 1/0.
  - Required response: PCs come out in order 0x00400000..0x00400024 with no loss or duplication.
- Misaligned fetch (macro defined):
  - Stimulus: pc_i=0x00400002.
  - Required response: no imem_req_o, and dec_valid_o with dec_exc_o=1 and dec_pc_o=0x00400002.
  - Required response: requests resume only after flush_i.
